// File: rtl/ffbank_arb.sv
// ffbank_arb: round-robin arbiter writing 4 requesters into a bank of enable flops.
// Optional burst-lock feature enabled by defining FFARB_LOCK_EN.
module ffbank_arb #(
    parameter int WIDTH       = 8,
    parameter int NBANK       = 4,
    parameter int AW          = 4,
    parameter int INIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               R,
    input  logic [3:0]         req,
    input  logic [3:0]         lock,
    input  logic [4*AW-1:0]    req_addr,
    input  logic [4*WIDTH-1:0] req_data,
    output logic [3:0]         gnt,
    output logic               err,
    output logic               busy,
    output logic               init_done,
    output logic [NBANK-1:0]   ff_E,
    output logic [WIDTH-1:0]   ff_D,
    output logic               ff_Rn
);
    typedef enum logic [1:0] {INIT, ARB, WRITE} state_t;
    state_t state, n_state;
    logic [3:0] cnt, n_cnt;
    logic [1:0] rr, n_rr, sel, n_sel, pk;
    logic burst, n_burst;
    logic [AW-1:0] lat_addr, n_addr, live_addr, wa;
    logic [WIDTH-1:0] lat_data, n_data, live_data, wd, n_d;
    logic [3:0] n_gnt;
    logic [NBANK-1:0] n_e;
    logic n_err, n_rn, n_done;

    // lowest offset from rr with a pending request wins
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        pick = p;
        for (int k = 3; k >= 0; k--)
            if (r[p + 2'(k)]) pick = p + 2'(k);
    endfunction

    assign pk        = pick(req, rr);
    assign live_addr = req_addr[sel*AW +: AW];
    assign live_data = req_data[sel*WIDTH +: WIDTH];
    // burst continuation words come straight from the requester, already updated after its last gnt
    assign wa        = burst ? live_addr : lat_addr;
    assign wd        = burst ? live_data : lat_data;

`ifndef FFARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    always_comb begin
        n_state = state;
        n_cnt   = cnt;
        n_rr    = rr;
        n_sel   = sel;
        n_burst = burst;
        n_addr  = lat_addr;
        n_data  = lat_data;
        n_gnt   = '0;
        n_e     = '0;
        n_err   = 1'b0;
        n_d     = ff_D;
        n_rn    = ff_Rn;
        n_done  = init_done;
        case (state)
            INIT: begin
                n_cnt = cnt + 4'd1;
                if (cnt == 4'(INIT_CYCLES - 1)) begin
                    n_state = ARB;
                    n_rn    = 1'b1;
                    n_done  = 1'b1;
                end
            end
            ARB: if (|req) begin
                n_sel   = pk;
                n_addr  = req_addr[pk*AW +: AW];
                n_data  = req_data[pk*WIDTH +: WIDTH];
                n_burst = 1'b0;
                n_state = WRITE;
            end
            WRITE: begin
                if (req[sel]) begin
                    n_gnt[sel] = 1'b1;
                    n_err      = int'(wa) >= NBANK;
                    n_e        = (int'(wa) < NBANK) ? NBANK'(1) << wa : '0;
                    n_d        = wd;
                end
                n_state = ARB;
                n_burst = 1'b0;
                n_rr    = req[sel] ? sel + 2'd1 : rr;
`ifdef FFARB_LOCK_EN
                if (req[sel] && lock[sel]) begin
                    n_state = WRITE;
                    n_burst = 1'b1;
                    n_rr    = rr;
                    n_addr  = live_addr;
                    n_data  = live_data;
                end
`endif
            end
            default: n_state = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state     <= INIT;
            cnt       <= '0;
            rr        <= '0;
            sel       <= '0;
            burst     <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            gnt       <= '0;
            err       <= 1'b0;
            ff_E      <= '0;
            ff_D      <= '0;
            ff_Rn     <= 1'b0;
            init_done <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= n_state;
            cnt       <= n_cnt;
            rr        <= n_rr;
            sel       <= n_sel;
            burst     <= n_burst;
            lat_addr  <= n_addr;
            lat_data  <= n_data;
            gnt       <= n_gnt;
            err       <= n_err;
            ff_E      <= n_e;
            ff_D      <= n_d;
            ff_Rn     <= n_rn;
            init_done <= n_done;
            busy      <= n_state != ARB;
        end
    end
endmodule

// File: tb/tb_ffbank_arb.sv
// tb_ffbank_arb: directed-vector bench for ffbank_arb (default parameters).
module tb_ffbank_arb;
    logic        clk = 1'b0;
    logic        R = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  lock = '0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt;
    logic        err, busy, init_done, ff_Rn;
    logic [3:0]  ff_E;
    logic [7:0]  ff_D;
    int vectors = 0;
    int errors = 0;

    ffbank_arb dut (
        .clk(clk), .R(R), .req(req), .lock(lock), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .err(err), .busy(busy), .init_done(init_done),
        .ff_E(ff_E), .ff_D(ff_D), .ff_Rn(ff_Rn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 4'b0 && n < 50);
        check("gnt_seen", {31'b0, |gnt}, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        R = 1'b1;
        @(negedge clk);
        R = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_init_done", {31'b0, init_done}, 1);
    endtask

    always @(negedge clk)
        check("onehot", {30'b0, $onehot0(gnt), $onehot0(ff_E)}, 2'b11);

    int n;
    logic [3:0] seq_g[4];
    logic [3:0] seq_e[4];
    logic [7:0] seq_d[4];
    int seq_n[4];
    int g1;

    initial begin
        #1 R = 1'b1;
        #1;
        check("rst_gnt", {28'b0, gnt}, 0);
        check("rst_ffE", {28'b0, ff_E}, 0);
        check("rst_ffD", {24'b0, ff_D}, 0);
        check("rst_flags", {27'b0, ff_Rn, init_done, busy, err}, 4'b0010);

        // power-up init with requester 0 already asking
        req = 4'b0001;
        req_addr[3:0] = 4'd0;
        req_data[7:0] = 8'h55;
        @(negedge clk);
        R = 1'b0;
        @(negedge clk);
        check("init1", {29'b0, ff_Rn, init_done, |gnt}, 3'b000);
        @(negedge clk);
        check("init2", {29'b0, ff_Rn, init_done, |gnt}, 3'b110);
        @(negedge clk);
        check("init3", {30'b0, |gnt, busy}, 2'b01);
        @(negedge clk);
        check("first_gnt", {28'b0, gnt}, 4'b0001);
        check("first_ffE", {28'b0, ff_E}, 4'b0001);
        check("first_ffD", {24'b0, ff_D}, 8'h55);
        req = '0;

        // all four continuously requesting
        do_reset();
        req_addr = {4'd3, 4'd2, 4'd1, 4'd0};
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(n);
            check($sformatf("rr_gnt%0d", i), {28'b0, gnt}, 4'b0001 << (i % 4));
            check($sformatf("rr_ffE%0d", i), {28'b0, ff_E}, 4'b0001 << (i % 4));
            check($sformatf("rr_ffD%0d", i), {24'b0, ff_D}, 8'hA0 + 8'(i % 4));
            if (i > 0) check($sformatf("rr_gap%0d", i), n, 2);
        end
        req = '0;
        repeat (3) @(negedge clk);
        check("idle", {22'b0, gnt, ff_E, busy, err}, 0);
        check("idle_ffD", {24'b0, ff_D}, 8'hA0);

        // out-of-range bank
        req_addr[11:8] = 4'd5;
        req_data[23:16] = 8'h77;
        req = 4'b0100;
        wait_gnt(n);
        check("oor_gnt", {28'b0, gnt}, 4'b0100);
        check("oor_err", {31'b0, err}, 1);
        check("oor_ffE", {28'b0, ff_E}, 0);
        req = '0;
        @(negedge clk);
        check("oor_err_clr", {31'b0, err}, 0);

        // reset landing in the middle of a write
        req_addr[7:4] = 4'd2;
        req_data[15:8] = 8'h3C;
        req = 4'b0010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 20);
        check("abort_busy", {30'b0, busy, |gnt}, 2'b10);
        R = 1'b1;
        #1;
        check("abort_out", {25'b0, gnt, ff_E[2], ff_Rn, init_done}, 0);
        @(negedge clk);
        R = 1'b0;
        wait_gnt(n);
        check("retry_gnt", {28'b0, gnt}, 4'b0010);
        check("retry_ffE", {28'b0, ff_E}, 4'b0100);
        check("retry_ffD", {24'b0, ff_D}, 8'h3C);
        check("retry_done", {31'b0, init_done}, 1);
        req = '0;

        // requester 1 bursts three words with lock, requester 3 waiting
        do_reset();
        req_addr[7:4] = 4'd0;
        req_data[15:8] = 8'h11;
        req_addr[15:12] = 4'd3;
        req_data[31:24] = 8'h33;
        lock = 4'b0010;
        req = 4'b1010;
        g1 = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(n);
            seq_g[i] = gnt;
            seq_e[i] = ff_E;
            seq_d[i] = ff_D;
            seq_n[i] = n;
            if (gnt[1]) begin
                g1++;
                req_data[15:8] = 8'h11 + 8'(g1);
                if (g1 == 2) lock[1] = 1'b0;
                if (g1 == 3) req[1] = 1'b0;
            end
            if (gnt[3]) req[3] = 1'b0;
        end
`ifdef FFARB_LOCK_EN
        check("lk_g", {16'b0, seq_g[0], seq_g[1], seq_g[2], seq_g[3]}, 16'h2228);
        check("lk_d", {seq_d[0], seq_d[1], seq_d[2], seq_d[3]}, 32'h11121333);
        check("lk_gap", {8'b0, 8'(seq_n[1]), 8'(seq_n[2]), 8'(seq_n[3])}, 24'h010102);
`else
        check("lk_g", {16'b0, seq_g[0], seq_g[1], seq_g[2], seq_g[3]}, 16'h2822);
        check("lk_d", {seq_d[0], seq_d[1], seq_d[2], seq_d[3]}, 32'h11331213);
        check("lk_gap", {8'b0, 8'(seq_n[1]), 8'(seq_n[2]), 8'(seq_n[3])}, 24'h020202);
`endif
        check("lk_e", {16'b0, seq_e[0], seq_e[1], seq_e[2], seq_e[3]},
              {16'b0, seq_g[0][3] ? 4'h8 : 4'h1, seq_g[1][3] ? 4'h8 : 4'h1,
               seq_g[2][3] ? 4'h8 : 4'h1, seq_g[3][3] ? 4'h8 : 4'h1});
        req = '0;
        lock = '0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ffbank_arb.md
FFBANK_ARB -- requirements
Module: ffbank_arb

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH, 8, data bits per bank word.
  NBANK, 4, number of enable-flop banks (2..16).
  AW, 4, requester address width; banks addressed 0..NBANK-1.
  INIT_CYCLES, 2, cycles ff_Rn is held low after reset release (1..15).
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all state changes on posedge.
  R  in  1  reset, asynchronous, active-high.
  req  in  4  per-requester write request.
  lock  in  4  per-requester burst lock; ignored unless FFARB_LOCK_EN.
  req_addr  in  4*AW  bank index; requester i at [i*AW +: AW].
  req_data  in  4*WIDTH  write data; requester i at [i*WIDTH +: WIDTH].
  gnt  out  4  one-hot, one-cycle acceptance pulse.
  err  out  1  one-cycle pulse with gnt when granted addr >= NBANK.
  busy  out  1  high in INIT and WRITE.
  init_done  out  1  high once INIT completes.
  ff_E  out  NBANK  one-hot bank enable (drives the bank flops' E pins).
  ff_D  out  WIDTH  shared bank data (drives the bank flops' D pins).
  ff_Rn  out  1  active-low bank clear (drives the bank flops' R pins).

Function
REQ-003 FSM states SHALL be INIT, ARB, WRITE; all outputs registered.
REQ-004 INIT: ff_Rn=0 for exactly INIT_CYCLES clk edges after R falls; then ff_Rn=1, init_done=1, go to ARB.
REQ-005 Requests SHALL be ignored in INIT; no gnt is issued.
REQ-006 ARB: if any req set, select by round-robin starting at pointer rr (0..3, wraps 3->0); latch index, addr, data; go to WRITE next edge.
REQ-007 WRITE (one cycle): gnt[sel]=1, ff_D=latched data, ff_E[addr]=1 if addr<NBANK; bank flop captures at the following edge.
REQ-008 addr>=NBANK: gnt[sel]=1, err=1, ff_E all zero, no bank written.
REQ-009 After WRITE: rr=sel+1 mod 4; return to ARB. Unlocked throughput: one write per 2 cycles.
REQ-010 Requester SHALL hold req, addr, data stable until its gnt; req deasserted before gnt cancels it with no effect.
REQ-011 With req=0 in ARB: gnt=0, ff_E=0, busy=0; ff_D holds last value.
REQ-012 Simultaneous req from all four, continuously held: grant order 0,1,2,3,0,... from rr=0.
REQ-013 At most one gnt bit and at most one ff_E bit SHALL be high in any cycle.

Reset
REQ-014 R=1 SHALL immediately (asynchronously) force: state INIT, rr=0, gnt=0, err=0, ff_E=0, ff_D=0, ff_Rn=0, init_done=0, busy=1.
REQ-015 R asserted during WRITE SHALL abort it: ff_E drops asynchronously, no gnt issued for that write; requester retries.
REQ-016 INIT_CYCLES count restarts on each R release.

Configuration
REQ-017 Macro FFARB_LOCK_EN defined: in WRITE, if req[sel] and lock[sel] are high, stay in WRITE, re-latch that requester's addr/data, and issue gnt/ff_E every cycle (one write per cycle); rr updates only when leaving WRITE.
REQ-018 FFARB_LOCK_EN undefined: lock port present but unused; behaviour per REQ-009.

Verification
REQ-019 R pulse, INIT_CYCLES=2, req[0]=1 throughout -> ff_Rn low 2 cycles, init_done rises, gnt[0] first seen 2 cycles after init_done.
REQ-020 req=4'b1111, addrs 0..3, data 8'hA0..8'hA3 -> gnt order 0,1,2,3 on alternate cycles; ff_E=0001,0010,0100,1000 with ff_D=A0..A3.
REQ-021 req[2]=1, addr=5, NBANK=4 -> gnt[2]=1, err=1, ff_E=0.
REQ-022 R asserted mid-WRITE -> ff_E and gnt 0 within same cycle, ff_Rn=0, re-INIT; write reissued after init_done.
REQ-023 FFARB_LOCK_EN, req[1]=lock[1]=1 for 3 writes, req[3] pending -> gnt[1] 3 consecutive cycles, then gnt[3].
REQ-024 Without FFARB_LOCK_EN, same stimulus -> gnt alternates 1,3,1 on alternate cycles.
